// File: rtl/fd2e_bank.sv
// WIDTH x DEPTH register pipeline with async clear and a full-length scan chain, advanced by cp.
// Optional per-stage even parity with error injection is built when FD_BANK_PARITY_EN is defined.
module fd2e_bank #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 1,
   parameter int CP_MODE = 0
) (
   input  logic             sys_clk,
   input  logic             cd,
   input  logic             cp,
   input  logic [WIDTH-1:0] d,
   input  logic             te,
   input  logic             ti,
`ifdef FD_BANK_PARITY_EN
   input  logic             pinj,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             to
`ifdef FD_BANK_PARITY_EN
   ,
   output logic             perr
`endif
);

   localparam int NBITS = WIDTH * DEPTH;

   // Stage k occupies chain bits [k*WIDTH +: WIDTH]; the scan path is then a plain left shift.
   logic [NBITS-1:0] chain_q, chain_d;
   logic             cp_low_q, cp_low_d;
   logic             adv;

   // cp_low_q records "cp was low last cycle"; clearing it to 0 means a cp already high at
   // release does not count as a rising edge.
   always_comb begin
      cp_low_d = ~cp;
      if (CP_MODE == 0) begin
         adv = cp;
      end else begin
         adv = cp & cp_low_q;
      end
   end

   always_comb begin
      chain_d = chain_q;
      if (adv) begin
         if (te) begin
            chain_d    = chain_q << 1;
            chain_d[0] = ti;
         end else begin
            chain_d              = chain_q << WIDTH;
            chain_d[WIDTH-1:0]   = d;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge cd) begin
      if (!cd) begin
         chain_q  <= '0;
         cp_low_q <= 1'b0;
      end else begin
         chain_q  <= chain_d;
         cp_low_q <= cp_low_d;
      end
   end

   assign q  = chain_q[NBITS-1 -: WIDTH];
   assign qn = ~chain_q[NBITS-1 -: WIDTH];
   assign to = chain_q[NBITS-1];

`ifdef FD_BANK_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;

   // Scan recomputes parity from the shifted data, so scanning can never raise perr.
   always_comb begin
      par_d = par_q;
      if (adv) begin
         if (te) begin
            for (int k = 0; k < DEPTH; k++) begin
               par_d[k] = ^chain_d[k*WIDTH +: WIDTH];
            end
         end else begin
            par_d    = par_q << 1;
            par_d[0] = (^d) ^ pinj;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge cd) begin
      if (!cd) begin
         par_q <= '0;
      end else begin
         par_q <= par_d;
      end
   end

   assign perr = (^chain_q[NBITS-1 -: WIDTH]) ^ par_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_fd2e_bank.sv
// Bench for fd2e_bank: three configurations side by side, a stage-array model checked every
// cycle, plus directed literal checks. Parity checks are built when FD_BANK_PARITY_EN is defined.
module tb_fd2e_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       cd;
   logic       cp_i[3], te_i[3], ti_i[3], pinj_i[3];
   logic [7:0] d_i[3];

   logic [7:0] q_a, qn_a, q_b, qn_b;
   logic [3:0] q_c, qn_c;
   logic       to_a, to_b, to_c;
`ifdef FD_BANK_PARITY_EN
   logic       perr_a, perr_b, perr_c;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // a: 8 bits x 3 stages, level cp; b: 8 x 1, edge cp; c: 4 x 2, level cp
   fd2e_bank #(.WIDTH(8), .DEPTH(3), .CP_MODE(0)) u_a (
      .sys_clk(clk), .cd(cd), .cp(cp_i[0]), .d(d_i[0]), .te(te_i[0]), .ti(ti_i[0]),
`ifdef FD_BANK_PARITY_EN
      .pinj(pinj_i[0]), .perr(perr_a),
`endif
      .q(q_a), .qn(qn_a), .to(to_a));

   fd2e_bank #(.WIDTH(8), .DEPTH(1), .CP_MODE(1)) u_b (
      .sys_clk(clk), .cd(cd), .cp(cp_i[1]), .d(d_i[1]), .te(te_i[1]), .ti(ti_i[1]),
`ifdef FD_BANK_PARITY_EN
      .pinj(pinj_i[1]), .perr(perr_b),
`endif
      .q(q_b), .qn(qn_b), .to(to_b));

   fd2e_bank #(.WIDTH(4), .DEPTH(2), .CP_MODE(0)) u_c (
      .sys_clk(clk), .cd(cd), .cp(cp_i[2]), .d(d_i[2][3:0]), .te(te_i[2]), .ti(ti_i[2]),
`ifdef FD_BANK_PARITY_EN
      .pinj(pinj_i[2]), .perr(perr_c),
`endif
      .q(q_c), .qn(qn_c), .to(to_c));

   logic [7:0] dq[3], dqn[3];
   logic       dto[3];
   assign dq[0]  = q_a;
   assign dq[1]  = q_b;
   assign dq[2]  = {4'h0, q_c};
   assign dqn[0] = qn_a;
   assign dqn[1] = qn_b;
   assign dqn[2] = {4'h0, qn_c};
   assign dto[0] = to_a;
   assign dto[1] = to_b;
   assign dto[2] = to_c;
`ifdef FD_BANK_PARITY_EN
   logic dperr[3];
   assign dperr[0] = perr_a;
   assign dperr[1] = perr_b;
   assign dperr[2] = perr_c;
`endif

   // ---------------- model: explicit stage array, bit-by-bit scan ----------------
   int         mw[3] = '{8, 8, 4};
   int         md[3] = '{3, 1, 2};
   int         mm[3] = '{0, 1, 0};
   logic [7:0] ms[3][3];
   logic       mp[3][3];
   logic       mprev[3];

   function automatic logic [7:0] mask_of(input int i);
      return (mw[i] == 8) ? 8'hFF : 8'h0F;
   endfunction

   task automatic model_step(input int i);
      logic adv;
      adv = (mm[i] == 1) ? (cp_i[i] && !mprev[i]) : cp_i[i];
      mprev[i] = cp_i[i];
      if (adv) begin
         if (!te_i[i]) begin
            for (int k = md[i] - 1; k > 0; k--) begin
               ms[i][k] = ms[i][k-1];
               mp[i][k] = mp[i][k-1];
            end
            ms[i][0] = d_i[i] & mask_of(i);
            mp[i][0] = (^(d_i[i] & mask_of(i))) ^ pinj_i[i];
         end else begin
            for (int k = md[i] - 1; k >= 0; k--) begin
               for (int b = mw[i] - 1; b >= 0; b--) begin
                  if (b > 0)      ms[i][k][b] = ms[i][k][b-1];
                  else if (k > 0) ms[i][k][0] = ms[i][k-1][mw[i]-1];
                  else            ms[i][0][0] = ti_i[i];
               end
            end
            for (int k = 0; k < md[i]; k++) mp[i][k] = ^ms[i][k];
         end
      end
   endtask

   // A cp that is already high at release is treated as "previously high": no edge.
   always @(posedge clk or negedge cd) begin
      if (!cd) begin
         for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
               ms[i][k] = 8'h00;
               mp[i][k] = 1'b0;
            end
            mprev[i] = 1'b1;
         end
      end else begin
         for (int i = 0; i < 3; i++) model_step(i);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic [7:0] e;
         e = ms[i][md[i]-1];
         chk($sformatf("model_q[%0d]", i),  dq[i],  e);
         chk($sformatf("model_qn[%0d]", i), dqn[i], ~e & mask_of(i));
         chk($sformatf("model_to[%0d]", i), {7'h0, dto[i]}, {7'h0, e[mw[i]-1]});
`ifdef FD_BANK_PARITY_EN
         chk($sformatf("model_perr[%0d]", i), {7'h0, dperr[i]}, {7'h0, (^e) ^ mp[i][md[i]-1]});
`endif
      end
   end

   // ---------------- driver ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic seq[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      cd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cp_i[i] = 1'b0; te_i[i] = 1'b0; ti_i[i] = 1'b0; pinj_i[i] = 1'b0; d_i[i] = 8'h00;
      end
      step(2);
      chk("reset_q_a", q_a, 8'h00);
      chk("reset_qn_a", qn_a, 8'hFF);
      cd = 1'b1;

      // async clear mid-cycle; b has cp high from release so it must not advance
      cp_i[0] = 1'b1; d_i[0] = 8'hFF;
      cp_i[1] = 1'b1; d_i[1] = 8'h77;
      step(3);
      chk("fill_q_a", q_a, 8'hFF);
      chk("cp_high_release_q_b", q_b, 8'h00);
      @(posedge clk);
      #2;
      cd = 1'b0;
      #1;
      chk("async_q_a", q_a, 8'h00);
      chk("async_qn_a", qn_a, 8'hFF);
      chk("async_to_a", {7'h0, to_a}, 8'h00);
      @(posedge clk);
      #1;
      cd = 1'b1;
      step(2);
      chk("cp_high_release2_q_b", q_b, 8'h00);

      // edge mode: one advance per rising edge of cp
      cp_i[0] = 1'b0;
      cp_i[1] = 1'b0;
      step(1);
      cp_i[1] = 1'b1; d_i[1] = 8'h11; step(1);
      d_i[1] = 8'h22; step(1);
      d_i[1] = 8'h33; step(1);
      d_i[1] = 8'h44; step(1);
      chk("edge_one_adv_q_b", q_b, 8'h11);
      cp_i[1] = 1'b0; step(1);
      cp_i[1] = 1'b1; d_i[1] = 8'h55; step(1);
      chk("edge_second_adv_q_b", q_b, 8'h55);
      cp_i[1] = 1'b0;

      // latency DEPTH=3 then hold
      cp_i[0] = 1'b1; d_i[0] = 8'hA5;
      step(2);
      chk("latency_2_q_a", q_a, 8'hFF);
      step(1);
      chk("latency_3_q_a", q_a, 8'hA5);
      cp_i[0] = 1'b0; d_i[0] = 8'h3C;
      step(5);
      chk("hold_q_a", q_a, 8'hA5);
      chk("hold_qn_a", qn_a, 8'h5A);

      // scan through 4x2 chain
      te_i[2] = 1'b1; cp_i[2] = 1'b1; ti_i[2] = 1'b1;
      step(1);
      ti_i[2] = 1'b0;
      step(6);
      chk("scan_7_to_c", {7'h0, to_c}, 8'h00);
      step(1);
      chk("scan_8_to_c", {7'h0, to_c}, 8'h01);
      te_i[2] = 1'b0; d_i[2] = 8'h06; step(1);
      d_i[2] = 8'h09; step(1);
      chk("pload_q_c", {4'h0, q_c}, 8'h06);
      te_i[2] = 1'b1; ti_i[2] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("shift_out_%0d", j), {7'h0, to_c}, {7'h0, seq[j]});
         if (j < 7) step(1);
      end

      // reset mid-shift, then refill from an empty chain
      ti_i[2] = 1'b1;
      step(3);
      @(posedge clk);
      #2;
      cd = 1'b0;
      #1;
      chk("midshift_q_c", {4'h0, q_c}, 8'h00);
      chk("midshift_to_c", {7'h0, to_c}, 8'h00);
      @(posedge clk);
      #1;
      cd = 1'b1;
      ti_i[2] = 1'b1; step(1);
      ti_i[2] = 1'b0; step(6);
      chk("refill_7_to_c", {7'h0, to_c}, 8'h00);
      step(1);
      chk("refill_8_to_c", {7'h0, to_c}, 8'h01);

`ifdef FD_BANK_PARITY_EN
      te_i[2] = 1'b0; d_i[2] = 8'h01; pinj_i[2] = 1'b1; step(1);
      pinj_i[2] = 1'b0; d_i[2] = 8'h03; step(1);
      chk("perr_inject", {7'h0, perr_c}, 8'h01);
      d_i[2] = 8'h00; step(1);
      chk("perr_clean", {7'h0, perr_c}, 8'h00);
      te_i[2] = 1'b1; ti_i[2] = 1'b1; step(4);
      chk("perr_scan", {7'h0, perr_c}, 8'h00);
`endif

      cp_i[2] = 1'b0; te_i[2] = 1'b0;
      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
